dmem_access_unit: RTL and testbench

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/pqr5_core_pkg.sv | 46 ++++
 rtl/load_data_aligner.sv | 44 ++++
 rtl/dmem_access_unit.sv | 145 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pqr5_core_pkg.sv
// ---------------------------------------------------------------------------
// pqr5_core_pkg
// Shared types and helpers for the pqr5 core data-memory path.
//   XLEN          : data/address width
//   mem_size_t    : access size encoding (BYTE / HWORD / WORD, 2'b11 acts as WORD)
//   dmem_state_t  : data-memory access FSM states
//   byte_enables  : byte-lane enable decode for a given size and address offset
//   is_misaligned : natural-alignment check for a given size and address offset
// ---------------------------------------------------------------------------
package pqr5_core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } dmem_state_t;

  // Offsets that do not fit the access size are not rejected here; the
  // low address bits simply steer the lanes.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] off);
    case (size)
      BYTE:    return 4'b0001 << off;
      HWORD:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      BYTE:    return 1'b0;
      HWORD:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// ---------------------------------------------------------------------------
// load_data_aligner
// Combinational lane select and sign/zero extension of a load data word.
//   rdata       in  XLEN  raw memory read word
//   byte_off    in  2     byte address bits [1:0] of the access
//   size        in  2     access size (mem_size_t encoding)
//   ld_unsigned in  1     1 = zero-extend, 0 = sign-extend
//   data        out XLEN  aligned, extended load result
// ---------------------------------------------------------------------------
module load_data_aligner
  import pqr5_core_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        fill;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_lane = rdata[8*byte_off +: 8];
    half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
    fill      = 1'b0;
    data      = rdata;
    case (size)
      BYTE: begin
        fill = ~ld_unsigned & byte_lane[7];
        data = {{(XLEN-8){fill}}, byte_lane};
      end
      HWORD: begin
        fill = ~ld_unsigned & half_lane[15];
        data = {{(XLEN-16){fill}}, half_lane};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
// Issues one load or store at a time to a req/gnt + rvalid data memory and
// returns aligned, extended load data.
// Optional feature: define PQR5_DMEM_MISALIGN_CHK_EN to reject misaligned
// HWORD/WORD accesses with a one-cycle o_misalign pulse instead of issuing them.
//   clk, sreset         clock, synchronous active-high reset
//   i_mem_cmd/addr/size/data, i_ld_unsigned, i_bubble : upstream command
//   o_stall             upstream holds its command while 1 (state != IDLE)
//   o_dmem_req/we/addr/be/wdata, i_dmem_gnt            : memory request
//   i_dmem_rvalid/rdata                                 : memory read return
//   o_ld_valid/o_ld_data                                : load result pulse
//   o_misalign          misaligned-access pulse (0 unless feature enabled)
// ---------------------------------------------------------------------------
module dmem_access_unit
  import pqr5_core_pkg::*;
(
  input  logic            clk,
  input  logic            sreset,
  input  logic            i_mem_cmd,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [1:0]      i_mem_size,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_ld_unsigned,
  input  logic            i_bubble,
  output logic            o_stall,
  output logic            o_dmem_req,
  input  logic            i_dmem_gnt,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_ld_valid,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_misalign
);

  dmem_state_t     state, state_nxt;
  logic            accept;
  logic            misaligned_cmd;
  logic            ld_done;

  logic            cmd_q;
  logic            unsigned_q;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] data_q;
  logic            ld_valid_q;
  logic [XLEN-1:0] ld_data_q;
  logic [XLEN-1:0] aligned_data;

`ifdef PQR5_DMEM_MISALIGN_CHK_EN
  logic misalign_q;

  assign misaligned_cmd = is_misaligned(i_mem_size, i_mem_addr[1:0]);

  always_ff @(posedge clk) begin
    if (sreset) misalign_q <= 1'b0;
    else        misalign_q <= (state == IDLE) && !i_bubble && misaligned_cmd;
  end

  assign o_misalign = misalign_q;
`else
  assign misaligned_cmd = 1'b0;
  assign o_misalign     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (sreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    o_stall    = 1'b1;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_dmem_be  = 4'b0000;
    case (state)
      IDLE: begin
        o_stall = 1'b0;
        if (!i_bubble && !misaligned_cmd) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = cmd_q;
        o_dmem_be  = byte_enables(size_q, addr_q[1:0]);
        if (i_dmem_gnt) state_nxt = cmd_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (i_dmem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only a WAIT-state rvalid completes a load; stray rvalids are dropped.
  assign ld_done = (state == WAIT) && i_dmem_rvalid;

  load_data_aligner u_aligner (
    .rdata       (i_dmem_rdata),
    .byte_off    (addr_q[1:0]),
    .size        (size_q),
    .ld_unsigned (unsigned_q),
    .data        (aligned_data)
  );

  // Command fields are captured once at accept so the request stays stable
  // for as long as the memory withholds gnt.
  always_ff @(posedge clk) begin
    if (sreset) begin
      cmd_q      <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      data_q     <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      if (accept) begin
        cmd_q      <= i_mem_cmd;
        unsigned_q <= i_ld_unsigned;
        addr_q     <= i_mem_addr;
        size_q     <= i_mem_size;
        data_q     <= i_mem_data;
      end
      ld_valid_q <= ld_done;
      if (ld_done) ld_data_q <= aligned_data;
    end
  end

  assign o_dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_wdata = data_q;
  assign o_ld_valid   = ld_valid_q;
  assign o_ld_data    = ld_data_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
// Directed self-checking bench for dmem_access_unit. Expected values are
// hand-computed constants. Build with +define+PQR5_DMEM_MISALIGN_CHK_EN to
// exercise the misalignment-reject variant.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        sreset;
  logic        i_mem_cmd;
  logic [31:0] i_mem_addr;
  logic [1:0]  i_mem_size;
  logic [31:0] i_mem_data;
  logic        i_ld_unsigned;
  logic        i_bubble;
  logic        o_stall;
  logic        o_dmem_req;
  logic        i_dmem_gnt;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_ld_valid;
  logic [31:0] o_ld_data;
  logic        o_misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_access_unit dut (
    .clk           (clk),
    .sreset        (sreset),
    .i_mem_cmd     (i_mem_cmd),
    .i_mem_addr    (i_mem_addr),
    .i_mem_size    (i_mem_size),
    .i_mem_data    (i_mem_data),
    .i_ld_unsigned (i_ld_unsigned),
    .i_bubble      (i_bubble),
    .o_stall       (o_stall),
    .o_dmem_req    (o_dmem_req),
    .i_dmem_gnt    (i_dmem_gnt),
    .o_dmem_we     (o_dmem_we),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_be     (o_dmem_be),
    .o_dmem_wdata  (o_dmem_wdata),
    .i_dmem_rvalid (i_dmem_rvalid),
    .i_dmem_rdata  (i_dmem_rdata),
    .o_ld_valid    (o_ld_valid),
    .o_ld_data     (o_ld_data),
    .o_misalign    (o_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load: accept, one REQ cycle with gnt, one WAIT cycle with rvalid.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    i_mem_cmd = 1'b0; i_mem_addr = addr; i_mem_size = size;
    i_ld_unsigned = uns; i_bubble = 1'b0;
    step();
    i_bubble = 1'b1;
    check({tag, " req"},   32'(o_dmem_req), 32'd1);
    check({tag, " we"},    32'(o_dmem_we),  32'd0);
    check({tag, " addr"},  o_dmem_addr,     exp_addr);
    check({tag, " be"},    32'(o_dmem_be),  32'(exp_be));
    check({tag, " stall"}, 32'(o_stall),    32'd1);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    check({tag, " wait req"}, 32'(o_dmem_req), 32'd0);
    check({tag, " wait vld"}, 32'(o_ld_valid), 32'd0);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
    step();
    i_dmem_rvalid = 1'b0;
    check({tag, " ld_valid"}, 32'(o_ld_valid), 32'd1);
    check({tag, " ld_data"},  o_ld_data,       exp_data);
    check({tag, " stall end"}, 32'(o_stall),   32'd0);
    step();
    check({tag, " pulse end"}, 32'(o_ld_valid), 32'd0);
    check({tag, " hold"},      o_ld_data,       exp_data);
  endtask

  initial begin
    sreset = 1'b1; i_mem_cmd = 1'b0; i_mem_addr = '0; i_mem_size = 2'b00;
    i_mem_data = '0; i_ld_unsigned = 1'b0; i_bubble = 1'b1;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;

    // Reset state
    step(); step();
    check("rst stall",    32'(o_stall),    32'd0);
    check("rst req",      32'(o_dmem_req), 32'd0);
    check("rst we",       32'(o_dmem_we),  32'd0);
    check("rst be",       32'(o_dmem_be),  32'd0);
    check("rst addr",     o_dmem_addr,     32'h0);
    check("rst wdata",    o_dmem_wdata,    32'h0);
    check("rst ld_valid", 32'(o_ld_valid), 32'd0);
    check("rst ld_data",  o_ld_data,       32'h0);
    check("rst misalign", 32'(o_misalign), 32'd0);
    sreset = 1'b0;

    // Stray gnt/rvalid while idle must do nothing
    i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
    step(); step();
    check("idle gnt req",   32'(o_dmem_req), 32'd0);
    check("idle rv valid",  32'(o_ld_valid), 32'd0);
    check("idle rv data",   o_ld_data,       32'h0);
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;

    // LB signed, top byte
    do_load("LB",  32'h0000_1003, 2'b00, 1'b0, 32'h80AA_BBCC, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    // LHU upper half
    do_load("LHU", 32'h0000_2002, 2'b01, 1'b1, 32'hBEEF_1234, 32'h0000_2000, 4'b1100, 32'h0000_BEEF);
    // LH signed lower half
    do_load("LH",  32'h0000_0500, 2'b01, 1'b0, 32'h1234_8001, 32'h0000_0500, 4'b0011, 32'hFFFF_8001);
    // LBU byte 1
    do_load("LBU", 32'h0000_0601, 2'b00, 1'b1, 32'h0000_F000, 32'h0000_0600, 4'b0010, 32'h0000_00F0);
    // LW aligned, size 2'b11 behaves as WORD
    do_load("LW11", 32'h0000_0700, 2'b11, 1'b0, 32'h8765_4321, 32'h0000_0700, 4'b1111, 32'h8765_4321);

    // SW with gnt withheld three cycles; rvalid in REQ must be ignored
    i_mem_cmd = 1'b1; i_mem_addr = 32'h0000_3000; i_mem_size = 2'b10;
    i_mem_data = 32'hDEAD_BEEF; i_bubble = 1'b0;
    step();
    i_bubble = 1'b1; i_mem_data = 32'h0; i_mem_addr = 32'h0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      check("SW req",   32'(o_dmem_req), 32'd1);
      check("SW we",    32'(o_dmem_we),  32'd1);
      check("SW addr",  o_dmem_addr,     32'h0000_3000);
      check("SW wdata", o_dmem_wdata,    32'hDEAD_BEEF);
      check("SW be",    32'(o_dmem_be),  32'hF);
      check("SW stall", 32'(o_stall),    32'd1);
      check("SW vld",   32'(o_ld_valid), 32'd0);
      step();
    end
    i_dmem_rvalid = 1'b0;
    check("SW stall4", 32'(o_stall), 32'd1);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    check("SW done stall", 32'(o_stall),    32'd0);
    check("SW done req",   32'(o_dmem_req), 32'd0);
    check("SW no vld",     32'(o_ld_valid), 32'd0);
    step();
    check("SW no vld2",    32'(o_ld_valid), 32'd0);
    check("SW ld hold",    o_ld_data,       32'h8765_4321);

    // Reset while a load waits for rvalid
    i_mem_cmd = 1'b0; i_mem_addr = 32'h0000_4000; i_mem_size = 2'b10; i_bubble = 1'b0;
    step();
    i_bubble = 1'b1; i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    check("RST wait stall", 32'(o_stall), 32'd1);
    sreset = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    step();
    sreset = 1'b0;
    check("RST stall",   32'(o_stall),    32'd0);
    check("RST req",     32'(o_dmem_req), 32'd0);
    check("RST vld",     32'(o_ld_valid), 32'd0);
    check("RST ld_data", o_ld_data,       32'h0);
    check("RST addr",    o_dmem_addr,     32'h0);
    step();
    check("RST late rv vld",  32'(o_ld_valid), 32'd0);
    check("RST late rv data", o_ld_data,       32'h0);
    i_dmem_rvalid = 1'b0;

    // Misaligned LW at 0x1001
`ifdef PQR5_DMEM_MISALIGN_CHK_EN
    i_mem_cmd = 1'b0; i_mem_addr = 32'h0000_1001; i_mem_size = 2'b10; i_bubble = 1'b0;
    step();
    i_bubble = 1'b1;
    check("MIS pulse", 32'(o_misalign), 32'd1);
    check("MIS req",   32'(o_dmem_req), 32'd0);
    check("MIS stall", 32'(o_stall),    32'd0);
    step();
    check("MIS pulse end", 32'(o_misalign), 32'd0);
    check("MIS req2",      32'(o_dmem_req), 32'd0);
`else
    do_load("LWMIS", 32'h0000_1001, 2'b10, 1'b0, 32'h1122_3344, 32'h0000_1000, 4'b1111, 32'h1122_3344);
    check("MIS tied", 32'(o_misalign), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
